// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rob_pkg
// Purpose  : Shared sizes, index types and the entry record for the reorder
//            buffer.
// Revision : 1.0 - initial release
// ============================================================================
package rob_pkg;

  localparam int WAYS     = 4;
  localparam int ROB_SIZE = 32;
  localparam int PRF      = 64;

  localparam int ROB_W = $clog2(ROB_SIZE);
  localparam int PRF_W = $clog2(PRF);
  localparam int ARF_W = 5;
  localparam int CNT_W = $clog2(ROB_SIZE) + 1;
  localparam int SPC_W = $clog2(WAYS) + 1;

  typedef logic [ROB_W-1:0] rob_idx_t;
  typedef logic [PRF_W-1:0] prf_idx_t;
  typedef logic [ARF_W-1:0] arf_idx_t;
  typedef logic [CNT_W-1:0] count_t;
  typedef logic [SPC_W-1:0] space_t;

  typedef struct packed {
    logic     busy;
    logic     done;
    logic     mispredict;
    arf_idx_t arf;
    prf_idx_t prf;
  } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/rob_if.sv
`default_nettype none
// ============================================================================
// Module   : rob_if
// Purpose  : Dispatch, completion and commit signals of the reorder buffer.
//            slave = the ROB, master = the pipeline around it.
// Revision : 1.0 - initial release
// ============================================================================
interface rob_if;
  import rob_pkg::*;

  // dispatch from rename
  logic     [WAYS-1:0] dis_valid;
  arf_idx_t [WAYS-1:0] dis_arf_idx;
  prf_idx_t [WAYS-1:0] dis_prf_idx;
  logic     [WAYS-1:0] dis_accept;
  rob_idx_t [WAYS-1:0] dis_rob_idx;
  space_t              space_avail;

  // completion from the CDB
  logic     [WAYS-1:0] cdb_valid;
  rob_idx_t [WAYS-1:0] cdb_rob_idx;
  logic     [WAYS-1:0] cdb_mispredict;

  // retirement towards the RRAT
  logic     [WAYS-1:0] RRAT_idx_valid;
  arf_idx_t [WAYS-1:0] RRAT_ARF_idx;
  prf_idx_t [WAYS-1:0] RRAT_PRF_idx;
  logic     [WAYS-1:0] commit_valid;
  logic                except;
  logic                rob_empty;

  modport slave (
    input  dis_valid, dis_arf_idx, dis_prf_idx,
    input  cdb_valid, cdb_rob_idx, cdb_mispredict,
    output dis_accept, dis_rob_idx, space_avail,
    output RRAT_idx_valid, RRAT_ARF_idx, RRAT_PRF_idx,
    output commit_valid, except, rob_empty
  );

  modport master (
    output dis_valid, dis_arf_idx, dis_prf_idx,
    output cdb_valid, cdb_rob_idx, cdb_mispredict,
    input  dis_accept, dis_rob_idx, space_avail,
    input  RRAT_idx_valid, RRAT_ARF_idx, RRAT_PRF_idx,
    input  commit_valid, except, rob_empty
  );

endinterface
`default_nettype wire

// File: rtl/rob_commit_select.sv
`default_nettype none
// ============================================================================
// Module   : rob_commit_select
// Purpose  : Picks the in-order retiring prefix of the WAYS entries starting
//            at head. Retirement stops at the first entry that is not done
//            and stops after (including) the first mispredicted entry.
// Revision : 1.0 - initial release
// ============================================================================
module rob_commit_select
  import rob_pkg::*;
(
  input  rob_entry_t [WAYS-1:0] i_window,
  output logic       [WAYS-1:0] o_commit_valid,
  output logic                  o_except,
  output space_t                o_commit_cnt
);

  logic w_run;

  // Walk the lanes in program order, closing the group on a gap or a mispredict
  always_comb begin
    o_commit_valid = '0;
    o_except       = 1'b0;
    o_commit_cnt   = '0;
    w_run          = 1'b1;
    for (int k = 0; k < WAYS; k++) begin
      if (w_run && i_window[k].busy && i_window[k].done) begin
        o_commit_valid[k] = 1'b1;
        o_commit_cnt      = o_commit_cnt + space_t'(1);
        if (i_window[k].mispredict) begin
          o_except = 1'b1;
          w_run    = 1'b0;
        end
      end else begin
        w_run = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rob.sv
`default_nettype none
// ============================================================================
// Module   : rob
// Purpose  : Reorder buffer. Allocates up to WAYS entries per cycle in program
//            order, marks them done from the CDB and retires up to WAYS per
//            cycle into the RRAT. A retiring mispredict flushes everything.
// Revision : 1.0 - initial release
// ============================================================================
module rob
  import rob_pkg::*;
(
  input  logic clock,
  input  logic reset,
  rob_if.slave bus
);

  typedef logic [CNT_W:0] cnt_ext_t;

  rob_entry_t r_entries [ROB_SIZE];
  rob_entry_t w_next    [ROB_SIZE];
  rob_idx_t   r_head;
  rob_idx_t   r_tail;
  count_t     r_count;

  count_t                w_free;
  space_t                w_space;
  logic       [WAYS-1:0] w_accept;
  space_t                w_acc_cnt;
  space_t                w_com_cnt;
  rob_entry_t [WAYS-1:0] w_window;
  logic       [WAYS-1:0] w_commit;
  logic                  w_except;
  cnt_ext_t              w_count_next;

  // Space comes from the registered count only; this cycle's commits free
  // entries starting next cycle.
  assign w_free  = count_t'(ROB_SIZE) - r_count;
  assign w_space = (w_free >= count_t'(WAYS)) ? space_t'(WAYS) : space_t'(w_free);

  // Per-lane views: allocation index, commit window and RRAT drive
  for (genvar gi = 0; gi < WAYS; gi++) begin : g_lane
    assign bus.dis_rob_idx[gi]    = r_tail + rob_idx_t'(gi);
    assign w_window[gi]           = r_entries[r_head + rob_idx_t'(gi)];
    assign bus.RRAT_ARF_idx[gi]   = w_window[gi].arf;
    assign bus.RRAT_PRF_idx[gi]   = w_window[gi].prf;
    assign bus.RRAT_idx_valid[gi] = w_commit[gi] && (w_window[gi].arf != '0);
  end

  rob_commit_select u_commit_select (
    .i_window       (w_window),
    .o_commit_valid (w_commit),
    .o_except       (w_except),
    .o_commit_cnt   (w_com_cnt)
  );

  assign bus.commit_valid = w_commit;
  assign bus.except       = w_except;
  assign bus.dis_accept   = w_accept;
  assign bus.space_avail  = w_space;
  assign bus.rob_empty    = (r_count == '0);

  // Grant contiguous dispatch lanes that fit, none while flushing
  always_comb begin
    w_accept  = '0;
    w_acc_cnt = '0;
    for (int i = 0; i < WAYS; i++) begin
      w_accept[i] = bus.dis_valid[i] && (space_t'(i) < w_space) && !w_except;
      w_acc_cnt   = w_acc_cnt + space_t'(w_accept[i]);
    end
  end

  assign w_count_next = cnt_ext_t'(r_count) + cnt_ext_t'(w_acc_cnt) - cnt_ext_t'(w_com_cnt);

  // Next entry contents: CDB completion, then retire clears, then allocation
  always_comb begin
    w_next = r_entries;
    for (int w = 0; w < WAYS; w++) begin
      if (bus.cdb_valid[w] && r_entries[bus.cdb_rob_idx[w]].busy) begin
        w_next[bus.cdb_rob_idx[w]].done       = 1'b1;
        w_next[bus.cdb_rob_idx[w]].mispredict = w_next[bus.cdb_rob_idx[w]].mispredict
                                              | bus.cdb_mispredict[w];
      end
    end
    for (int k = 0; k < WAYS; k++) begin
      if (w_commit[k]) begin
        w_next[r_head + rob_idx_t'(k)] = '0;
      end
    end
    for (int i = 0; i < WAYS; i++) begin
      if (w_accept[i]) begin
        w_next[r_tail + rob_idx_t'(i)] = '{busy:       1'b1,
                                           done:       1'b0,
                                           mispredict: 1'b0,
                                           arf:        bus.dis_arf_idx[i],
                                           prf:        bus.dis_prf_idx[i]};
      end
    end
  end

  // State update; reset and a retiring mispredict both empty the buffer
  always_ff @(posedge clock) begin
    if (reset || w_except) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int e = 0; e < ROB_SIZE; e++) begin
        r_entries[e] <= '0;
      end
    end else begin
      r_head    <= r_head + rob_idx_t'(w_com_cnt);
      r_tail    <= r_tail + rob_idx_t'(w_acc_cnt);
      r_count   <= count_t'(w_count_next);
      r_entries <= w_next;
    end
  end

  // Occupancy must stay within 0..ROB_SIZE
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (w_count_next <= cnt_ext_t'(ROB_SIZE));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rob.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob
// Purpose  : Self-checking bench for rob: queue-based reference model checked
//            every cycle, plus directed scenarios with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rob;
  import rob_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rob_if bus ();

  rob dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: program-order queue ----------------
  typedef struct {
    int idx;
    int arf;
    int prf;
    bit done;
    bit misp;
  } ment_t;

  ment_t mq[$];
  int    m_tail = 0;
  bit    m_init = 1'b0;

  always @(negedge clk) begin
    int         space;
    int         ncom;
    bit         exc;
    bit         stop;
    logic [3:0] e_cv;
    logic [3:0] e_rv;
    logic [3:0] e_acc;
    logic [19:0] e_ri;
    ment_t      ne;

    space = ROB_SIZE - mq.size();
    if (space > WAYS) space = WAYS;
    e_cv = '0; e_rv = '0; exc = 1'b0; ncom = 0; stop = 1'b0;
    for (int k = 0; k < WAYS; k++) begin
      if (!stop && k < mq.size() && mq[k].done) begin
        e_cv[k] = 1'b1;
        ncom++;
        if (mq[k].arf != 0) e_rv[k] = 1'b1;
        if (mq[k].misp) begin
          exc  = 1'b1;
          stop = 1'b1;
        end
      end else begin
        stop = 1'b1;
      end
    end
    for (int i = 0; i < WAYS; i++) begin
      e_acc[i] = bus.dis_valid[i] && (i < space) && !exc;
      e_ri[i*5 +: 5] = 5'((m_tail + i) % ROB_SIZE);
    end

    if (m_init) begin
      check("model_dis_accept", 32'(bus.dis_accept), 32'(e_acc));
      check("model_dis_rob_idx", 32'(bus.dis_rob_idx), 32'(e_ri));
      check("model_space_avail", 32'(bus.space_avail), 32'(space));
      check("model_commit_valid", 32'(bus.commit_valid), 32'(e_cv));
      check("model_rrat_valid", 32'(bus.RRAT_idx_valid), 32'(e_rv));
      check("model_except", 32'(bus.except), 32'(exc));
      check("model_rob_empty", 32'(bus.rob_empty), 32'(mq.size() == 0));
      for (int k = 0; k < WAYS; k++) begin
        if (e_cv[k]) begin
          check("model_rrat_arf", 32'(bus.RRAT_ARF_idx[k]), 32'(mq[k].arf));
          check("model_rrat_prf", 32'(bus.RRAT_PRF_idx[k]), 32'(mq[k].prf));
        end
      end
    end

    if (rst || exc) begin
      mq.delete();
      m_tail = 0;
      if (rst) m_init = 1'b1;
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        if (bus.cdb_valid[w]) begin
          for (int j = 0; j < mq.size(); j++) begin
            if (mq[j].idx == int'(bus.cdb_rob_idx[w])) begin
              mq[j].done = 1'b1;
              mq[j].misp = mq[j].misp | bus.cdb_mispredict[w];
            end
          end
        end
      end
      for (int k = 0; k < ncom; k++) void'(mq.pop_front());
      for (int i = 0; i < WAYS; i++) begin
        if (e_acc[i]) begin
          ne.idx  = m_tail;
          ne.arf  = int'(bus.dis_arf_idx[i]);
          ne.prf  = int'(bus.dis_prf_idx[i]);
          ne.done = 1'b0;
          ne.misp = 1'b0;
          mq.push_back(ne);
          m_tail = (m_tail + 1) % ROB_SIZE;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dis_valid      = '0;
    bus.dis_arf_idx    = '0;
    bus.dis_prf_idx    = '0;
    bus.cdb_valid      = '0;
    bus.cdb_rob_idx    = '0;
    bus.cdb_mispredict = '0;
  endtask

  task automatic dis(input int n, input int arf0, input int prf0);
    for (int i = 0; i < WAYS; i++) begin
      bus.dis_valid[i]   = (i < n);
      bus.dis_arf_idx[i] = arf_idx_t'(arf0 + i);
      bus.dis_prf_idx[i] = prf_idx_t'(prf0 + i);
    end
  endtask

  task automatic cdb(input int lane, input int idx, input bit misp);
    bus.cdb_valid[lane]      = 1'b1;
    bus.cdb_rob_idx[lane]    = rob_idx_t'(idx);
    bus.cdb_mispredict[lane] = misp;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    idle();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("reset_empty", 32'(bus.rob_empty), 32'd1);
    check("reset_space", 32'(bus.space_avail), 32'd4);
    check("reset_rob_idx", 32'(bus.dis_rob_idx), 32'({5'd3, 5'd2, 5'd1, 5'd0}));
    check("reset_commit", 32'(bus.commit_valid), 32'd0);
    check("reset_except", 32'(bus.except), 32'd0);

    // basic dispatch / complete / commit
    dis(4, 1, 40);
    #1;
    check("basic_accept", 32'(bus.dis_accept), 32'hf);
    check("basic_rob_idx", 32'(bus.dis_rob_idx), 32'({5'd3, 5'd2, 5'd1, 5'd0}));
    tick();
    idle();
    for (int i = 0; i < 4; i++) cdb(i, i, 1'b0);
    tick();
    idle();
    #1;
    check("basic_commit", 32'(bus.commit_valid), 32'hf);
    check("basic_rrat_valid", 32'(bus.RRAT_idx_valid), 32'hf);
    check("basic_rrat_arf", 32'(bus.RRAT_ARF_idx), 32'({5'd4, 5'd3, 5'd2, 5'd1}));
    check("basic_rrat_prf", 32'(bus.RRAT_PRF_idx), 32'({6'd43, 6'd42, 6'd41, 6'd40}));
    tick();
    #1;
    check("basic_empty_after", 32'(bus.rob_empty), 32'd1);

    // fill to 32 entries (head = tail = 4)
    for (int g = 0; g < 8; g++) begin
      dis(4, g * 3 + 1, g * 4);
      tick();
    end
    idle();
    dis(4, 5, 5);
    #1;
    check("full_space", 32'(bus.space_avail), 32'd0);
    check("full_accept", 32'(bus.dis_accept), 32'd0);
    tick();
    idle();
    cdb(0, 4, 1'b0);
    cdb(1, 5, 1'b0);
    tick();
    idle();
    #1;
    check("full_commit2", 32'(bus.commit_valid), 32'h3);
    check("full_space_same_cycle", 32'(bus.space_avail), 32'd0);
    tick();
    dis(4, 9, 60);
    #1;
    check("freed_space", 32'(bus.space_avail), 32'd2);
    check("freed_accept", 32'(bus.dis_accept), 32'h3);
    tick();

    // gap at entry 8 stops commit
    idle();
    cdb(0, 6, 1'b0);
    cdb(1, 7, 1'b0);
    cdb(2, 9, 1'b0);
    tick();
    idle();
    #1;
    check("gap_commit", 32'(bus.commit_valid), 32'h3);
    tick();
    cdb(0, 8, 1'b0);
    tick();
    idle();
    #1;
    check("gap_filled_commit", 32'(bus.commit_valid), 32'h3);
    tick();

    // mispredict at entry 11 (lane 1 of head=10)
    cdb(0, 10, 1'b0);
    cdb(1, 11, 1'b1);
    cdb(2, 12, 1'b0);
    cdb(3, 13, 1'b0);
    tick();
    idle();
    dis(4, 1, 1);
    #1;
    check("misp_commit", 32'(bus.commit_valid), 32'h3);
    check("misp_except", 32'(bus.except), 32'd1);
    check("misp_accept", 32'(bus.dis_accept), 32'd0);
    tick();
    idle();
    #1;
    check("flush_empty", 32'(bus.rob_empty), 32'd1);
    check("flush_space", 32'(bus.space_avail), 32'd4);
    check("flush_rob_idx", 32'(bus.dis_rob_idx), 32'({5'd3, 5'd2, 5'd1, 5'd0}));
    check("flush_except", 32'(bus.except), 32'd0);

    // advance head and tail to 30 with pipelined dispatch/complete
    for (int g = 0; g < 8; g++) begin
      idle();
      if (g < 7) dis(4, g + 1, g * 4);
      else       dis(2, 20, 10);
      if (g > 0) for (int i = 0; i < 4; i++) cdb(i, (g - 1) * 4 + i, 1'b0);
      tick();
    end
    idle();
    cdb(0, 28, 1'b0);
    cdb(1, 29, 1'b0);
    tick();
    idle();
    repeat (2) tick();
    #1;
    check("wrap_pre_empty", 32'(bus.rob_empty), 32'd1);
    dis(4, 7, 50);
    bus.dis_arf_idx[2] = '0;
    bus.dis_arf_idx[3] = arf_idx_t'(9);
    #1;
    check("wrap_rob_idx", 32'(bus.dis_rob_idx), 32'({5'd1, 5'd0, 5'd31, 5'd30}));
    check("wrap_accept", 32'(bus.dis_accept), 32'hf);
    tick();
    idle();
    cdb(0, 30, 1'b0);
    cdb(1, 31, 1'b0);
    cdb(2, 0, 1'b0);
    cdb(3, 1, 1'b0);
    tick();
    idle();
    #1;
    check("wrap_commit", 32'(bus.commit_valid), 32'hf);
    check("wrap_arf0_rrat_valid", 32'(bus.RRAT_idx_valid), 32'b1011);
    check("wrap_rrat_prf", 32'(bus.RRAT_PRF_idx), 32'({6'd53, 6'd52, 6'd51, 6'd50}));
    tick();
    #1;
    check("wrap_head_tail", 32'(bus.dis_rob_idx), 32'({5'd5, 5'd4, 5'd3, 5'd2}));

    // CDB to a free entry is ignored
    idle();
    cdb(0, 2, 1'b1);
    cdb(1, 7, 1'b0);
    tick();
    idle();
    dis(1, 3, 33);
    tick();
    idle();
    #1;
    check("free_cdb_no_commit", 32'(bus.commit_valid), 32'd0);
    check("free_cdb_not_empty", 32'(bus.rob_empty), 32'd0);
    tick();
    cdb(0, 2, 1'b0);
    tick();
    idle();
    #1;
    check("free_cdb_later_commit", 32'(bus.commit_valid), 32'h1);
    check("free_cdb_no_except", 32'(bus.except), 32'd0);
    tick();

    // reset in the middle of traffic
    dis(4, 1, 10);
    tick();
    idle();
    cdb(0, 3, 1'b0);
    cdb(1, 4, 1'b0);
    dis(4, 5, 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    #1;
    check("midrst_empty", 32'(bus.rob_empty), 32'd1);
    check("midrst_commit", 32'(bus.commit_valid), 32'd0);
    check("midrst_space", 32'(bus.space_avail), 32'd4);
    check("midrst_rob_idx", 32'(bus.dis_rob_idx), 32'({5'd3, 5'd2, 5'd1, 5'd0}));
    check("midrst_except", 32'(bus.except), 32'd0);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer sitting directly downstream of the rename stage (RAT/RRAT, free list, valid list).
- Allocates in-order entries for up to WAYS renamed instructions per cycle and tracks completion from the CDB.
- Retires up to WAYS instructions per cycle in program order, driving the RRAT write ports (ARF idx, PRF idx, valid).
- Raises except when a mispredicted instruction retires, so rename state rolls back to the RRAT.

Parameters:
- WAYS, 4, superscalar width for dispatch, completion and commit.
- ROB_SIZE, 32, number of entries; must be a power of 2 and at least WAYS.
- PRF, 64, physical register count; PRF tag width is $clog2(PRF).

Ports:
- clock  in  1  system clock
- reset  in  1  reset; one clock; reset is synchronous and active-high
- dis_valid  in  [WAYS]  lane i holds a renamed instruction; lanes are contiguous from lane 0
- dis_arf_idx  in  [WAYS][5]  architectural destination; 0 means no destination
- dis_prf_idx  in  [WAYS][$clog2(PRF)]  physical destination (rename_result)
- dis_accept  out  [WAYS]  lane i was allocated this cycle
- dis_rob_idx  out  [WAYS][$clog2(ROB_SIZE)]  entry index assigned to lane i (tail+i)
- space_avail  out  [$clog2(WAYS)+1]  min(WAYS, free entries)
- cdb_valid  in  [WAYS]  completion broadcast valid
- cdb_rob_idx  in  [WAYS][$clog2(ROB_SIZE)]  completing entry index
- cdb_mispredict  in  [WAYS]  completing instruction was a mispredicted branch
- RRAT_idx_valid  out  [WAYS]  committing lane writes the RRAT
- RRAT_ARF_idx  out  [WAYS][5]  committing ARF index
- RRAT_PRF_idx  out  [WAYS][$clog2(PRF)]  committing PRF index
- commit_valid  out  [WAYS]  lane i retires an instruction, with or without a destination
- except  out  1  a mispredicted instruction retires this cycle
- rob_empty  out  1  count == 0

Behaviour:
- State:
  - head and tail pointers (mod ROB_SIZE) and count (0..ROB_SIZE).
  - Per entry: busy, done, mispredict, arf, prf.
- Reset:
  - head = tail = count = 0; all busy/done/mispredict bits cleared.
  - Outputs: commit_valid, RRAT_idx_valid and except all 0; rob_empty = 1; space_avail = WAYS; dis_rob_idx[i] = i.
- Dispatch:
  - dis_accept[i] = dis_valid[i] && i < space_avail && !except.
  - space_avail is computed from the registered count only; same-cycle commits do not free space until the next cycle.
  - Each accepted entry is written the next edge with busy=1, done=0, mispredict=0, arf, prf.
  - tail advances by the number of accepted lanes.
  - Non-contiguous dis_valid patterns are undefined.
- Completion:
  - For each cdb_valid lane: if the entry is busy, set done=1 and mispredict |= cdb_mispredict.
  - CDB to a non-busy entry is ignored.
  - Completion is visible to commit the cycle after the CDB (no bypass).
- Commit (combinational from the registered state):
  - Lane k considers entry head+k and retires if busy && done and all lanes j<k retired and none of them was mispredicted.
  - Commit is therefore in order and stops after the first not-done entry or after the first mispredicted entry, inclusive.
  - RRAT_idx_valid[k] = commit_valid[k] && arf != 0.
  - Lanes after a mispredicted lane are always low; the RRAT relies on this.
- Commit update: head advances by the commit count; retired entries are cleared to busy=0.
- Except:
  - except = OR of commit_valid[k] && mispredict on that entry. It is combinational in the commit cycle, so the RAT takes RRAT_next, which includes this cycle's commits.
  - Next edge: every entry is cleared; head = tail = count = 0; that cycle's dispatch and CDB writes are discarded.
- Count: count_next = count + accepted − committed, range-checked by assertion 0..ROB_SIZE.
- Full: count == ROB_SIZE gives space_avail = 0 and no dis_accept.
- Wrap: index arithmetic is mod ROB_SIZE, so an allocation or commit group may straddle entry ROB_SIZE−1 → 0.
- Simultaneous dispatch and commit in one cycle is allowed.
- Reset mid-operation overrides except, dispatch, CDB and commit.

Decomposition:
- Package rob_pkg holds:
  - constants WAYS, ROB_SIZE, PRF;
  - typedefs rob_idx_t, prf_idx_t, arf_idx_t;
  - struct rob_entry_t {busy, done, mispredict, arf, prf}.
- One sub-module, rob_commit_select: combinational; takes the WAYS entries starting at head and produces commit_valid, except and the commit count.

Test Plan:
- Reset, then dispatch 4 lanes (arf 1-4, prf 40-43) → dis_rob_idx 0-3 and dis_accept 1111; CDB completes 0-3 → next cycle commit_valid 1111 and RRAT outputs (1,40)…(4,43); rob_empty afterwards.
- Fill to 32 entries → space_avail 0 and dis_valid 1111 gives dis_accept 0000. Then commit 2 → space_avail 2 next cycle, and dispatch of 4 accepts lanes 0-1 only.
- Complete entries 0,1,3 but not 2 → commit_valid 0011; completing 2 later → entries 2,3 commit together.
- Entry 1 completes with cdb_mispredict, entries 0-3 all done → commit_valid 0011 and except=1 the same cycle, with dis_valid asserted → next cycle count 0, head = tail = 0, nothing accepted.
- Head at 30 with 4 done entries → commit indices 30,31,0,1 with correct wrap; head becomes 2.
- dis_arf_idx 0 → that lane has commit_valid=1 and RRAT_idx_valid=0. CDB to a free entry has no effect. Reset asserted mid-stream → all outputs return to reset values the next cycle.
